// File: rtl/timer_arbiter_pkg.sv
// timer_arbiter_pkg: shared FSM state type and default sizing for timer_arbiter.
package timer_arbiter_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 32;
endpackage

// File: rtl/timer_arbiter_rr_select.sv
// rr_select: picks one requester; round-robin from ptr_i with TIMER_ARBITER_RR_EN, else lowest index wins.
module rr_select #(
  parameter int N_REQ = 4,
  parameter int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] win_o,
  output logic [IW-1:0]    idx_o
);
  logic found;
  int j;
`ifndef TIMER_ARBITER_RR_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr_i;
`endif
  always_comb begin
    win_o = '0;
    idx_o = '0;
    found = 1'b0;
    j = 0;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef TIMER_ARBITER_RR_EN
      j = (int'(ptr_i) + k) % N_REQ;
`else
      j = k;
`endif
      if (!found && req_i[j]) begin
        found = 1'b1;
        idx_o = IW'(j);
        win_o[j] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/timer_arbiter.sv
// timer_arbiter: N_REQ requesters share one interval counter; one owner counts its period then pulses done.
// Define TIMER_ARBITER_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module timer_arbiter
  import timer_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] period,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [WIDTH-1:0]       count
);
  localparam int IW = $clog2(N_REQ);
  state_e state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, per_q, per_d, slice;
  logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d, win;
  logic [IW-1:0] own_q, own_d, ptr, win_idx;
  logic busy_q;
  rr_select #(.N_REQ(N_REQ), .IW(IW)) u_sel (
    .req_i(req),
    .ptr_i(ptr),
    .win_o(win),
    .idx_o(win_idx)
  );
  assign slice = period[win_idx*WIDTH +: WIDTH];
`ifdef TIMER_ARBITER_RR_EN
  logic [IW-1:0] ptr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= '0;
    else if (state_q == IDLE && |req) ptr_q <= (win_idx == IW'(N_REQ-1)) ? '0 : win_idx + 1'b1;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    per_d = per_q;
    own_d = own_q;
    gnt_d = gnt_q;
    done_d = '0;
    if (state_q == IDLE) begin
      count_d = '0;
      gnt_d = '0;
      if (|req) begin
        state_d = RUN;
        own_d = win_idx;
        gnt_d = win;
        per_d = (slice == '0) ? WIDTH'(1) : slice;
      end
    end else if (state_q == RUN) begin
      // abort takes precedence over completion: a dropped request never earns a done pulse
      if (!req[own_q]) begin
        state_d = IDLE;
        count_d = '0;
        gnt_d = '0;
      end else if (count_q == per_q - WIDTH'(1)) begin
        state_d = DONE;
        gnt_d = '0;
        done_d = gnt_q;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end else begin
      state_d = IDLE;
      count_d = '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      per_q <= '0;
      own_q <= '0;
      gnt_q <= '0;
      done_q <= '0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      per_q <= per_d;
      own_q <= own_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
      busy_q <= (state_d != IDLE);
    end
  assign gnt = gnt_q;
  assign done = done_q;
  assign busy = busy_q;
  assign count = count_q;
endmodule

// File: tb/tb_timer_arbiter.sv
// tb_timer_arbiter: directed and randomized checks of timer_arbiter against an interval-level reference model.
module tb_timer_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] period = '0;
  logic [N-1:0] gnt, done;
  logic busy;
  logic [W-1:0] count;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  // reference model: who owns the counter, how long the interval is, how many RUN cycles remain
  int m_mode = 0;
  int m_own = 0;
  int m_len = 0;
  int m_left = 0;
  int m_ptr = 0;
  logic [N-1:0] e_gnt, e_done;
  logic e_busy;
  logic [W-1:0] e_cnt;

  timer_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req), .period(period),
    .gnt(gnt), .done(done), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef TIMER_ARBITER_RR_EN
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
`else
    for (int k = 0; k < N; k++) if (r[k]) return k;
`endif
    return 0;
  endfunction

  task automatic calc_exp();
    e_gnt = (m_mode == 1) ? N'(1) << m_own : '0;
    e_done = (m_mode == 2) ? N'(1) << m_own : '0;
    e_busy = (m_mode != 0);
    e_cnt = (m_mode == 1) ? W'(m_len - m_left) : (m_mode == 2) ? W'(m_len - 1) : '0;
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_ptr = 0;
    calc_exp();
  endtask

  task automatic tick();
    int p;
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else begin
      if (m_mode == 0) begin
        if (req != 0) begin
          m_own = pick(req, m_ptr);
          p = int'(period[m_own*W +: W]);
          m_len = (p == 0) ? 1 : p;
          m_left = m_len;
          m_ptr = (m_own + 1) % N;
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (!req[m_own]) m_mode = 0;
        else if (m_left == 1) m_mode = 2;
        else m_left--;
      end else m_mode = 0;
      calc_exp();
    end
    #1;
  endtask

  task automatic set_period(input int i, input int v);
    period[i*W +: W] = W'(v);
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({gnt, done, busy, count} !== '0) begin errors++; $display("FAIL reset_async got %h exp 0", {gnt, done, busy, count}); end
    req = 4'b1111;
    tick();
    tick();
    checks++;
    if ({gnt, done, busy, count} !== '0) begin errors++; $display("FAIL reset_held got %h exp 0", {gnt, done, busy, count}); end
    rst = 1'b0;
    req = '0;
    tick();
    checks++;
    if ({gnt, done, busy, count} !== {e_gnt, e_done, e_busy, e_cnt}) begin errors++; $display("FAIL reset_idle got %h exp %h", {gnt, done, busy, count}, {e_gnt, e_done, e_busy, e_cnt}); end
  endtask

  task automatic test_single();
    int done_at = -1;
    set_period(0, 5);
    req = 4'b0001;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if ({gnt, done, busy, count} !== {e_gnt, e_done, e_busy, e_cnt}) begin errors++; $display("FAIL single_model c%0d got %h exp %h", i, {gnt, done, busy, count}, {e_gnt, e_done, e_busy, e_cnt}); end
      if (i <= 5) begin
        checks++;
        if (gnt !== 4'b0001 || count !== W'(i - 1)) begin errors++; $display("FAIL single_run c%0d gnt %b count %0d exp 0001 %0d", i, gnt, count, i - 1); end
      end
      if (done != 0 && done_at < 0) done_at = i;
      if (i == 6) req = '0;
    end
    checks++;
    if (done_at != 6) begin errors++; $display("FAIL single_done_cycle got %0d exp 6", done_at); end
  endtask

  task automatic test_zero_period();
    set_period(2, 0);
    req = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100 || count !== '0 || done !== '0) begin errors++; $display("FAIL zero_run gnt %b count %0d done %b exp 0100 0 0000", gnt, count, done); end
    tick();
    checks++;
    if (done !== 4'b0100 || gnt !== '0 || count !== '0) begin errors++; $display("FAIL zero_done done %b gnt %b count %0d exp 0100 0000 0", done, gnt, count); end
    req = '0;
    tick();
    checks++;
    if ({gnt, done, busy, count} !== {e_gnt, e_done, e_busy, e_cnt}) begin errors++; $display("FAIL zero_idle got %h exp %h", {gnt, done, busy, count}, {e_gnt, e_done, e_busy, e_cnt}); end
  endtask

  task automatic test_contention();
    int order[$];
    int dones[$];
    logic [N-1:0] prev = '0;
    rst = 1'b1;
    #1;
    model_reset();
    #2;
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_period(i, 3);
`ifdef TIMER_ARBITER_RR_EN
    req = 4'b1111;
`else
    req = 4'b1010;
`endif
    for (int i = 1; i <= 25; i++) begin
      tick();
      checks++;
      if ({gnt, done, busy, count} !== {e_gnt, e_done, e_busy, e_cnt}) begin errors++; $display("FAIL contend_model c%0d got %h exp %h", i, {gnt, done, busy, count}, {e_gnt, e_done, e_busy, e_cnt}); end
      if (gnt != 0 && prev == 0) order.push_back($clog2(int'(gnt)));
      if (done != 0) dones.push_back(i);
      prev = gnt;
    end
    req = '0;
    checks++;
    if (order.size() != 5) begin errors++; $display("FAIL contend_grants got %0d exp 5", order.size()); end
    for (int i = 0; i < order.size(); i++) begin
`ifdef TIMER_ARBITER_RR_EN
      checks++;
      if (order[i] != i % N) begin errors++; $display("FAIL contend_order idx%0d got %0d exp %0d", i, order[i], i % N); end
`else
      checks++;
      if (order[i] != 1) begin errors++; $display("FAIL contend_fixed idx%0d got %0d exp 1", i, order[i]); end
`endif
    end
    for (int i = 1; i < dones.size(); i++) begin
      checks++;
      if (dones[i] - dones[i-1] != 5) begin errors++; $display("FAIL contend_spacing idx%0d got %0d exp 5", i, dones[i] - dones[i-1]); end
    end
    tick();
    tick();
  endtask

  task automatic test_abort();
    int n = 0;
    set_period(0, 10);
    req = 4'b0001;
    do begin tick(); n++; end while (count !== W'(4) && n < 20);
    checks++;
    if (count !== W'(4)) begin errors++; $display("FAIL abort_reach count %0d exp 4", count); end
    req = '0;
    tick();
    checks++;
    if (count !== '0 || gnt !== '0 || done !== '0) begin errors++; $display("FAIL abort count %0d gnt %b done %b exp 0 0000 0000", count, gnt, done); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({gnt, done, busy, count} !== {e_gnt, e_done, e_busy, e_cnt}) begin errors++; $display("FAIL abort_after got %h exp %h", {gnt, done, busy, count}, {e_gnt, e_done, e_busy, e_cnt}); end
    end
  endtask

  task automatic test_async_reset();
    int n = 0;
    set_period(0, 20);
    req = 4'b0001;
    do begin tick(); n++; end while (count !== W'(7) && n < 30);
    checks++;
    if (count !== W'(7)) begin errors++; $display("FAIL areset_reach count %0d exp 7", count); end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({gnt, done, busy, count} !== '0) begin errors++; $display("FAIL areset_mid got %h exp 0", {gnt, done, busy, count}); end
    #2;
    rst = 1'b0;
    req = 4'b0010;
    set_period(1, 2);
    tick();
    checks++;
    if (gnt !== 4'b0010 || done !== '0) begin errors++; $display("FAIL areset_regrant gnt %b done %b exp 0010 0000", gnt, done); end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) req = N'($urandom);
      for (int k = 0; k < N; k++) set_period(k, int'($urandom_range(0, 7)));
      tick();
      checks++;
      if ({gnt, done, busy, count} !== {e_gnt, e_done, e_busy, e_cnt}) begin errors++; $display("FAIL random c%0d got %h exp %h", i, {gnt, done, busy, count}, {e_gnt, e_done, e_busy, e_cnt}); end
    end
    req = '0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_zero_period();
    test_contention();
    test_abort();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 32, width of the shared interval counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  N_REQ  per-requester interval request, level.
REQ-006 SHALL have port period  input  N_REQ*WIDTH  flattened per-requester interval length; slice i = period[i*WIDTH +: WIDTH].
REQ-007 SHALL have port gnt  output  N_REQ  one-hot owner of the shared counter; zero when idle.
REQ-008 SHALL have port done  output  N_REQ  one-hot, one-cycle completion pulse to the owner.
REQ-009 SHALL have port busy  output  1  high while in RUN or DONE.
REQ-010 SHALL have port count  output  WIDTH  current shared counter value.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 IDLE: if any req bit is high, SHALL select one winner, latch its period slice, set count=0, assert gnt[winner], and go to RUN on the next edge (grant latency 1 cycle).
REQ-013 SHALL treat a latched period of 0 as 1.
REQ-014 RUN: count SHALL increment by 1 per cycle; when count == latched_period-1, next state SHALL be DONE.
REQ-015 An interval of P SHALL therefore occupy exactly P cycles in RUN, with count visiting 0..P-1.
REQ-016 DONE: done[owner] SHALL be high for exactly one cycle, gnt SHALL be 0, count SHALL hold P-1; next state SHALL be IDLE.
REQ-017 Abort: if req[owner] falls while in RUN, SHALL go to IDLE next edge, with no done pulse and count cleared to 0.
REQ-018 Changes to period[owner] during RUN SHALL be ignored.
REQ-019 Requests arriving during RUN/DONE SHALL wait; they are evaluated only in IDLE.
REQ-020 A requester holding req high after its done SHALL re-arbitrate normally in IDLE, so back-to-back intervals have a 1-cycle IDLE gap.
REQ-021 In IDLE: count=0, gnt=0, done=0, busy=0.
REQ-022 gnt, done, busy, count SHALL be registered outputs, with no combinational path from req.

Reset
REQ-023 rst high SHALL immediately force state IDLE, gnt=0, done=0, busy=0, count=0, and the round-robin pointer to requester 0, regardless of clk.
REQ-024 Reset asserted mid-interval SHALL discard the interval with no done pulse; after release, arbitration SHALL restart from IDLE.

Configuration
REQ-025 Macro TIMER_ARBITER_RR_EN defined: round-robin arbitration; the search starts at (last winner + 1) mod N_REQ, and the pointer updates only on grant.
REQ-026 Macro TIMER_ARBITER_RR_EN undefined: fixed priority, with the lowest index winning and no pointer state.

Structure
REQ-027 Package timer_arbiter_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the default WIDTH/N_REQ constants.
REQ-028 Winner selection SHALL live in sub-module rr_select (inputs: req and pointer; outputs: one-hot winner and index), with a fixed-priority mode selected by the macro.

Verification
REQ-029 Single request: req=4'b0001, period0=5 -> gnt=0001 one cycle after req; count 0..4 over 5 cycles; done=0001 for 1 cycle; then IDLE.
REQ-030 Zero period: period2=0, req=0100 -> exactly 1 RUN cycle (count=0), then done=0100.
REQ-031 Contention with RR_EN: req=1111 held, all periods=3 -> grant order 0,1,2,3,0; each done is separated by 5 cycles (3 RUN + DONE + IDLE).
REQ-032 Contention without RR_EN: req=1010 held -> requester 1 is granted every time; requester 3 is never granted.
REQ-033 Abort: period0=10; drop req0 when count=4 -> no done; count=0 and gnt=0 on the next edge.
REQ-034 Async reset: assert rst between clock edges while count=7 -> outputs are zero before the next edge; after release with req=0010, requester 1 is granted first.
